// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
// State encoding and counter width function.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_adder.sv
// One-bit full-adder cell driven by the serial adder controller.
// Purely combinational.
module adder (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic f,
  output logic cout
);

  assign f    = x ^ y ^ cin;
  assign cout = (x & y) | (cin & (x ^ y));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial LSB-first adder controller with valid/ready on both sides.
// Optional signed-overflow output enabled by SERIAL_ADDER_OVF_EN.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = cnt_w(WIDTH);

  state_t state, state_nx;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             f;
  logic             co;
  logic             accept;
  logic             last;

  assign accept = in_valid & in_ready;
  assign last   = (cnt == CNT_W'(WIDTH - 1));
  assign sum    = sum_sr;
  assign cout   = carry;

  adder u_adder (
    .x    (a_sr[0]),
    .y    (b_sr[0]),
    .cin  (carry),
    .f    (f),
    .cout (co)
  );

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = S_SHIFT;
      end
      S_SHIFT: begin
        if (last) state_nx = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && accept) begin
        a_sr  <= a;
        b_sr  <= b;
        carry <= cin;
        cnt   <= '0;
      end else if (state == S_SHIFT) begin
        sum_sr <= {f, sum_sr[WIDTH-1:1]};
        a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
        b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
        carry  <= co;
        if (!last) cnt <= cnt + CNT_W'(1);
      end
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  // carry still holds the carry into the MSB on the final shift edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (state == S_IDLE && accept) begin
      ovf <= 1'b0;
    end else if (state == S_SHIFT && last) begin
      ovf <= carry ^ co;
    end
  end
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Randomized self-checking bench for serial_adder_ctrl (WIDTH=32).
// Reference model uses plain wide arithmetic.
module tb_serial_adder_ctrl;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int pass_cnt = 0;
  int total = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  function automatic logic [W:0] ref_add(input logic [W-1:0] x,
                                         input logic [W-1:0] y,
                                         input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] x,
                                   input logic [W-1:0] y,
                                   input logic [W-1:0] s);
    return (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
  endfunction

  // Drive one op; returns at the first negedge with out_valid high
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic c, output int lat);
    int n;
    @(negedge clk);
    a = x; b = y; cin = c; in_valid = 1'b1; out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom; b = $urandom; cin = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got=%b exp=1", in_ready); else pass_cnt++;
    total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b exp=0", out_valid); else pass_cnt++;
    total++; if (sum !== '0) $display("FAIL rst_sum got=%h exp=0", sum); else pass_cnt++;
    total++; if (cout !== 1'b0) $display("FAIL rst_cout got=%b exp=0", cout); else pass_cnt++;
`ifdef SERIAL_ADDER_OVF_EN
    total++; if (ovf !== 1'b0) $display("FAIL rst_ovf got=%b exp=0", ovf); else pass_cnt++;
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_vector(input string name, input logic [W-1:0] x,
                             input logic [W-1:0] y, input logic c);
    int lat;
    logic [W:0] e;
    e = ref_add(x, y, c);
    run_op(x, y, c, lat);
    total++; if (lat !== 32) $display("FAIL %s_latency got=%0d exp=32", name, lat); else pass_cnt++;
    total++; if (sum !== e[W-1:0]) $display("FAIL %s_sum got=%h exp=%h", name, sum, e[W-1:0]); else pass_cnt++;
    total++; if (cout !== e[W]) $display("FAIL %s_cout got=%b exp=%b", name, cout, e[W]); else pass_cnt++;
`ifdef SERIAL_ADDER_OVF_EN
    total++;
    if (ovf !== ref_ovf(x, y, e[W-1:0]))
      $display("FAIL %s_ovf got=%b exp=%b", name, ovf, ref_ovf(x, y, e[W-1:0]));
    else pass_cnt++;
`endif
    finish_op();
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      test_vector("rand", $urandom, $urandom, 1'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [W:0] e;
    logic [W-1:0] x, y;
    x = $urandom; y = $urandom;
    e = ref_add(x, y, 1'b1);
    run_op(x, y, 1'b1, lat);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; a = ~x; b = ~y;
      @(negedge clk);
      total++; if (out_valid !== 1'b1) $display("FAIL bp_valid got=%b exp=1", out_valid); else pass_cnt++;
      total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready got=%b exp=0", in_ready); else pass_cnt++;
      total++; if (sum !== e[W-1:0]) $display("FAIL bp_sum got=%h exp=%h", sum, e[W-1:0]); else pass_cnt++;
      total++; if (cout !== e[W]) $display("FAIL bp_cout got=%b exp=%b", cout, e[W]); else pass_cnt++;
    end
    in_valid = 1'b0;
    finish_op();
    total++; if (out_valid !== 1'b0) $display("FAIL bp_release_valid got=%b exp=0", out_valid); else pass_cnt++;
    total++; if (in_ready !== 1'b1) $display("FAIL bp_release_ready got=%b exp=1", in_ready); else pass_cnt++;
  endtask

  task automatic test_reset_abort();
    int n;
    @(negedge clk);
    a = 32'hDEADBEEF; b = 32'h13579BDF; cin = 1'b1; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL abort_in_ready got=%b exp=1", in_ready); else pass_cnt++;
    total++; if (out_valid !== 1'b0) $display("FAIL abort_out_valid got=%b exp=0", out_valid); else pass_cnt++;
    total++; if (sum !== '0) $display("FAIL abort_sum got=%h exp=0", sum); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    test_vector("after_abort", 32'd3, 32'd5, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] xa[3], ya[3];
    logic         ca[3];
    int           acc[3];
    logic [W:0]   res[$];
    logic [W:0]   e;
    int k;
    for (int i = 0; i < 3; i++) begin
      xa[i] = $urandom; ya[i] = $urandom; ca[i] = 1'($urandom);
    end
    k = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 3 * 34 + 10; cyc++) begin
      @(negedge clk);
      if (out_valid) res.push_back({cout, sum});
      if (in_ready && k < 3) begin
        a = xa[k]; b = ya[k]; cin = ca[k]; in_valid = 1'b1;
        acc[k] = cyc;
        k++;
      end else if (k == 3 && !in_ready) begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    total++; if (k !== 3) $display("FAIL b2b_accepts got=%0d exp=3", k); else pass_cnt++;
    if (k == 3) begin
      total++; if (acc[1] - acc[0] !== 34) $display("FAIL b2b_gap0 got=%0d exp=34", acc[1] - acc[0]); else pass_cnt++;
      total++; if (acc[2] - acc[1] !== 34) $display("FAIL b2b_gap1 got=%0d exp=34", acc[2] - acc[1]); else pass_cnt++;
    end
    total++; if (res.size() !== 3) $display("FAIL b2b_results got=%0d exp=3", res.size()); else pass_cnt++;
    for (int i = 0; i < 3 && i < res.size(); i++) begin
      e = ref_add(xa[i], ya[i], ca[i]);
      total++; if (res[i] !== e) $display("FAIL b2b_result%0d got=%h exp=%h", i, res[i], e); else pass_cnt++;
    end
  endtask

  task automatic test_ovf();
    test_vector("ovf_pos", 32'h7FFFFFFF, 32'h00000001, 1'b0);
    test_vector("ovf_neg", 32'h80000000, 32'h80000000, 1'b0);
    test_vector("ovf_none", 32'h00000001, 32'h00000001, 1'b0);
  endtask

  initial begin
    test_reset();
    test_vector("carry_chain", 32'hFFFFFFFF, 32'h00000001, 1'b0);
    test_vector("mixed", 32'h12345678, 32'h9ABCDEF0, 1'b1);
    test_random();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    test_ovf();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
